// File: rtl/countdown_sequencer_pkg.sv
// Shared types and helpers for the BCD countdown sequencer.
// Imported by the interface, the prescaler and the top.
package timer_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_BUS_W  = DIGIT_W * MAX_DIGITS;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    // The caller zero-extends its bus, so unused upper digits read as zero.
    function automatic logic all_zero(input logic [MAX_BUS_W-1:0] bus);
        return (bus == '0);
    endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control and digit-bus bundle between the sequencer and its environment.
// The sequencer is the slave; the digit-cell side and host form the master.
interface countdown_sequencer_if #(
    parameter int NUM_DIGITS = 3
);
    import timer_pkg::*;

    logic                          start;
    logic                          pause;
    logic                          abort;
    logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
    logic                          dig_reconfig;
    logic                          dig_enable;
    logic                          dig_borrow_dn;
    logic                          busy;
    logic                          paused;
    logic                          done;
    logic                          expired_pls;

    modport master (
        output start,
        output pause,
        output abort,
        output digits_in,
        input  dig_reconfig,
        input  dig_enable,
        input  dig_borrow_dn,
        input  busy,
        input  paused,
        input  done,
        input  expired_pls
    );

    modport slave (
        input  start,
        input  pause,
        input  abort,
        input  digits_in,
        output dig_reconfig,
        output dig_enable,
        output dig_borrow_dn,
        output busy,
        output paused,
        output done,
        output expired_pls
    );

endinterface

// File: rtl/countdown_sequencer_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 step counter with clear and hold.
// tick marks the last count of each period.
module tick_prescaler #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over hold; the counter wraps at LAST and never passes it.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (!hold) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick  = (count_q == LAST);
    assign count = count_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Controller for a chain of cascaded BCD countdown digit cells.
// Loads 9s, paces decrement pulses and detects terminal count.
module countdown_sequencer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 1000,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_sequencer_if.slave  bus
);

    // Expiry is judged once the borrow ripple from the last pulse has settled.
    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(NUM_DIGITS + 1);

    state_t state_q;
    state_t state_d;

    logic             reconfig_q;
    logic             enable_q;
    logic             borrow_q;
    logic             busy_q;
    logic             paused_q;
    logic             done_q;
    logic             expired_q;

    logic             borrow_d;
    logic             done_d;
    logic             restartable;
    logic             expiry;

    logic             pre_clr;
    logic             pre_hold;
    logic             pre_tick;
    logic [CNT_W-1:0] pre_count;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (pre_clr),
        .hold  (pre_hold),
        .tick  (pre_tick),
        .count (pre_count)
    );

    // The count only advances in RUN, so it is frozen across PAUSE and
    // always restarts from zero on RUN entry after SETTLE.
    assign pre_clr  = bus.abort ||
                      !(state_q inside {ST_RUN, ST_PAUSE});
    assign pre_hold = (state_q != ST_RUN);

    assign restartable = state_q inside {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE};

    assign expiry = all_zero(MAX_BUS_W'(bus.digits_in)) &&
                    (pre_count == EXP_CNT);

    // Next state; abort beats start, start beats pause, pause beats expiry.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else if (bus.start && restartable) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_LOAD:   state_d = ST_SETTLE;
                ST_SETTLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (expiry) begin
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // A pulse is only issued when RUN continues, so any restart, pause,
    // abort or expiry in that cycle swallows it.
    assign borrow_d = (state_q == ST_RUN) &&
                      (state_d == ST_RUN) &&
                      pre_tick;

    // done is sticky; set on DONE entry, cleared by abort or a new load.
    assign done_d = (state_d == ST_DONE) ||
                    (done_q && !bus.abort && (state_d != ST_LOAD));

    // State and all outputs registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            reconfig_q <= 1'b0;
            enable_q   <= 1'b0;
            borrow_q   <= 1'b0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            reconfig_q <= (state_d == ST_LOAD);
            enable_q   <= (state_d == ST_RUN);
            borrow_q   <= borrow_d;
            busy_q     <= state_d inside {ST_LOAD, ST_SETTLE,
                                          ST_RUN, ST_PAUSE};
            paused_q   <= (state_d == ST_PAUSE);
            done_q     <= done_d;
            expired_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign bus.dig_reconfig  = reconfig_q;
    assign bus.dig_enable    = enable_q;
    assign bus.dig_borrow_dn = borrow_q;
    assign bus.busy          = busy_q;
    assign bus.paused        = paused_q;
    assign bus.done          = done_q;
    assign bus.expired_pls   = expired_q;

endmodule
